maxpool_layer: RTL



---
 rtl/maxpool_layer_pkg.sv | 27 ++
 rtl/maxpool_channel.sv | 80 ++++++++
 rtl/maxpool_layer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/maxpool_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_layer_pkg
// Brief    : Shared geometry, widths and sample type for the max-pool layer.
// Revision : 1.0
// ============================================================================
package maxpool_layer_pkg;

  // Counter width helper that never returns zero for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DATA_WIDTH = 69;
  localparam int OUT_WIDTH  = 32;
  localparam int IN_X       = 24;
  localparam int IN_Y       = 24;
  localparam int POOL_X     = IN_X / 2;
  localparam int POOL_Y     = IN_Y / 2;
  localparam int COL_W      = cnt_w(IN_X);
  localparam int ROW_W      = cnt_w(IN_Y);
  localparam int NUM_CH     = 8;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/maxpool_channel.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_channel
// Brief    : One channel of 2x2 max pooling: horizontal hold, half-width line
//            buffer, output register (saturating when MAXPOOL_OUT_SAT_EN).
// Revision : 1.0
// ============================================================================
module maxpool_channel
  import maxpool_layer_pkg::*;
#(
  parameter int DATA_WIDTH = maxpool_layer_pkg::DATA_WIDTH,
  parameter int DEPTH      = maxpool_layer_pkg::POOL_X,
  parameter int PW         = maxpool_layer_pkg::DATA_WIDTH,
  localparam int C_IDX_W   = cnt_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         beat_i,
  input  logic                         col_odd_i,
  input  logic                         row_odd_i,
  input  logic [C_IDX_W-1:0]           idx_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic signed [PW-1:0]         pool_o
);

  logic signed [DATA_WIDTH-1:0] hold_q;
  logic signed [DATA_WIDTH-1:0] line_buf_q [DEPTH];
  logic signed [DATA_WIDTH-1:0] w_h;
  logic signed [DATA_WIDTH-1:0] w_lb;
  logic signed [DATA_WIDTH-1:0] w_max;
  logic signed [PW-1:0]         pool_q;
  logic signed [PW-1:0]         pool_d;

  assign w_h   = (x_i > hold_q) ? x_i : hold_q;
  assign w_lb  = line_buf_q[idx_i];
  assign w_max = (w_lb > w_h) ? w_lb : w_h;

`ifdef MAXPOOL_OUT_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] C_SAT_MAX =
      {{(DATA_WIDTH-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] C_SAT_MIN = ~C_SAT_MAX;

  always_comb begin
    pool_d = w_max[PW-1:0];
    if (w_max > C_SAT_MAX) begin
      pool_d = C_SAT_MAX[PW-1:0];
    end else if (w_max < C_SAT_MIN) begin
      pool_d = C_SAT_MIN[PW-1:0];
    end
  end
`else
  always_comb begin
    pool_d = w_max;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      pool_q <= '0;
    end else if (beat_i) begin
      if (!col_odd_i) begin
        hold_q <= x_i;
      end else if (row_odd_i) begin
        pool_q <= pool_d;
      end
    end
  end

  // No reset: each entry is written on an even row before its odd-row read.
  always_ff @(posedge clk) begin
    if (beat_i && col_odd_i && !row_odd_i) begin
      line_buf_q[idx_i] <= w_h;
    end
  end

  assign pool_o = pool_q;

endmodule
`default_nettype wire

// File: rtl/maxpool_layer.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_layer
// Brief    : 2x2 stride-2 max pooling on 8 raster-ordered channels; shared
//            col/row counters plus valid/end-of-frame strobes.
//            Optional macro MAXPOOL_OUT_SAT_EN saturates outputs to OUT_WIDTH.
// Revision : 1.0
// ============================================================================
module maxpool_layer
  import maxpool_layer_pkg::*;
#(
  parameter int DATA_WIDTH = maxpool_layer_pkg::DATA_WIDTH,
  parameter int IN_X       = maxpool_layer_pkg::IN_X,
  parameter int IN_Y       = maxpool_layer_pkg::IN_Y,
  parameter int OUT_WIDTH  = maxpool_layer_pkg::OUT_WIDTH,
`ifdef MAXPOOL_OUT_SAT_EN
  localparam int PW        = OUT_WIDTH
`else
  // OUT_WIDTH is inert without saturation.
  localparam int PW        = (OUT_WIDTH > 0) ? DATA_WIDTH : DATA_WIDTH
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] relu_result_1,
  input  logic signed [DATA_WIDTH-1:0] relu_result_2,
  input  logic signed [DATA_WIDTH-1:0] relu_result_3,
  input  logic signed [DATA_WIDTH-1:0] relu_result_4,
  input  logic signed [DATA_WIDTH-1:0] relu_result_5,
  input  logic signed [DATA_WIDTH-1:0] relu_result_6,
  input  logic signed [DATA_WIDTH-1:0] relu_result_7,
  input  logic signed [DATA_WIDTH-1:0] relu_result_8,
  output logic signed [PW-1:0]         pool_result_1,
  output logic signed [PW-1:0]         pool_result_2,
  output logic signed [PW-1:0]         pool_result_3,
  output logic signed [PW-1:0]         pool_result_4,
  output logic signed [PW-1:0]         pool_result_5,
  output logic signed [PW-1:0]         pool_result_6,
  output logic signed [PW-1:0]         pool_result_7,
  output logic signed [PW-1:0]         pool_result_8,
  output logic                         pool_valid,
  output logic                         frame_done
);

  localparam int C_COL_W  = cnt_w(IN_X);
  localparam int C_ROW_W  = cnt_w(IN_Y);
  localparam int C_POOL_X = IN_X / 2;
  localparam int C_IDX_W  = cnt_w(C_POOL_X);
  localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(IN_X - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(IN_Y - 1);

  logic [C_COL_W-1:0] col_q, col_d;
  logic [C_ROW_W-1:0] row_q, row_d;
  logic               pool_valid_q, pool_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               w_col_last, w_row_last;
  logic [C_IDX_W-1:0] w_idx;

  assign w_col_last = (col_q == C_COL_LAST);
  assign w_row_last = (row_q == C_ROW_LAST);
  assign w_idx      = C_IDX_W'(col_q >> 1);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pool_valid_d = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      pool_valid_d = col_q[0] & row_q[0];
      frame_done_d = w_col_last & w_row_last;
      if (w_col_last) begin
        col_d = '0;
        row_d = w_row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pool_valid_q <= pool_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  logic signed [DATA_WIDTH-1:0] w_x    [NUM_CH];
  logic signed [PW-1:0]         w_pool [NUM_CH];

  assign w_x[0] = relu_result_1;
  assign w_x[1] = relu_result_2;
  assign w_x[2] = relu_result_3;
  assign w_x[3] = relu_result_4;
  assign w_x[4] = relu_result_5;
  assign w_x[5] = relu_result_6;
  assign w_x[6] = relu_result_7;
  assign w_x[7] = relu_result_8;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    maxpool_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (C_POOL_X),
      .PW         (PW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .beat_i    (in_valid),
      .col_odd_i (col_q[0]),
      .row_odd_i (row_q[0]),
      .idx_i     (w_idx),
      .x_i       (w_x[i]),
      .pool_o    (w_pool[i])
    );
  end

  assign pool_result_1 = w_pool[0];
  assign pool_result_2 = w_pool[1];
  assign pool_result_3 = w_pool[2];
  assign pool_result_4 = w_pool[3];
  assign pool_result_5 = w_pool[4];
  assign pool_result_6 = w_pool[5];
  assign pool_result_7 = w_pool[6];
  assign pool_result_8 = w_pool[7];
  assign pool_valid    = pool_valid_q;
  assign frame_done    = frame_done_q;

endmodule
`default_nettype wire
